// File: rtl/queue_controller.sv
// queue_controller: samples the arrival/departure buttons on the slow tick,
// arbitrates them into the 3-bit people count and runs a registered wait-time
// ROM lookup whenever the count or the teller count changes.
// Optional feature macro: QCTRL_COUNTDOWN_EN builds a wait-time countdown
// register behind wremain; without it wremain mirrors wtime.
module queue_controller #(
    parameter int MAX_COUNT = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       push_up,
    input  logic       push_down,
    input  logic [1:0] Tcount,
    output logic [2:0] count,
    output logic       full,
    output logic       empty,
    output logic       reject,
    output logic       busy,
    output logic [4:0] rom_addr,
    output logic       rom_en,
    input  logic [4:0] rom_data,
    output logic [4:0] wtime,
    output logic       wtime_valid,
    output logic [4:0] wremain
);

    localparam logic [2:0] MAX_C = 3'(MAX_COUNT);

    typedef enum logic [1:0] {IDLE, LOOKUP, CAPTURE} state_t;

    state_t     state, state_next;
    logic [1:0] tcount_q;
    logic       up_prev, dn_prev;
    logic       pending_up, pending_dn, pending_t;
    logic [1:0] pending_tv;
    logic       init_req;

    logic       up_edge, dn_edge, t_edge;
    logic       eff_up, eff_dn, eff_t, any_pend;
    logic [1:0] new_t;
    logic [2:0] count_next;
    logic [1:0] tq_next;
    logic       reject_next;
    logic       go;

    // Raw tick-qualified events; pending flags replay events that arrived while busy
    assign up_edge  = tick & push_up & ~up_prev;
    assign dn_edge  = tick & push_down & ~dn_prev;
    assign t_edge   = tick & (Tcount != tcount_q);
    assign eff_up   = up_edge | pending_up;
    assign eff_dn   = dn_edge | pending_dn;
    assign eff_t    = t_edge | pending_t;
    assign new_t    = t_edge ? Tcount : pending_tv;
    assign any_pend = pending_up | pending_dn | pending_t;

    assign full     = (count == MAX_C);
    assign empty    = (count == 3'd0);
    assign busy     = (state != IDLE);
    assign rom_en   = (state == LOOKUP);
    assign rom_addr = {tcount_q, count};

    // Arbitration, saturation and next-state selection
    always_comb begin
        count_next  = count;
        tq_next     = tcount_q;
        reject_next = 1'b0;
        go          = 1'b0;
        state_next  = state;
        case (state)
            IDLE: begin
                if (eff_up && !eff_dn) begin
                    if (count == MAX_C) reject_next = 1'b1;
                    else                count_next  = count + 3'd1;
                end else if (eff_dn && !eff_up) begin
                    if (count == 3'd0) reject_next = 1'b1;
                    else               count_next  = count - 3'd1;
                end
                if (eff_t) tq_next = new_t;
                go = (count_next != count) | (tq_next != tcount_q) | init_req | any_pend;
                if (go) state_next = LOOKUP;
            end
            LOOKUP:  state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, count, pending events and captured wait time
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 3'd0;
            tcount_q    <= 2'd0;
            up_prev     <= 1'b0;
            dn_prev     <= 1'b0;
            pending_up  <= 1'b0;
            pending_dn  <= 1'b0;
            pending_t   <= 1'b0;
            pending_tv  <= 2'd0;
            init_req    <= 1'b1;
            reject      <= 1'b0;
            wtime       <= 5'd0;
            wtime_valid <= 1'b0;
        end else begin
            state  <= state_next;
            reject <= reject_next;
            if (tick) begin
                up_prev <= push_up;
                dn_prev <= push_down;
            end
            if (state == IDLE) begin
                count      <= count_next;
                tcount_q   <= tq_next;
                pending_up <= 1'b0;
                pending_dn <= 1'b0;
                pending_t  <= 1'b0;
                if (go) begin
                    init_req    <= 1'b0;
                    wtime_valid <= 1'b0;
                end
            end else begin
                if (up_edge) pending_up <= 1'b1;
                if (dn_edge) pending_dn <= 1'b1;
                if (t_edge) begin
                    pending_t  <= 1'b1;
                    pending_tv <= Tcount;
                end
            end
            if (state == CAPTURE) begin
                wtime       <= rom_data;
                wtime_valid <= 1'b1;
            end
        end
    end

`ifdef QCTRL_COUNTDOWN_EN
    logic [4:0] wremain_r;

    // Countdown reloads on every capture and decrements once per idle tick
    always_ff @(posedge clk) begin
        if (reset)                                         wremain_r <= 5'd0;
        else if (state == CAPTURE)                         wremain_r <= rom_data;
        else if (state == IDLE && tick && wremain_r != 0)  wremain_r <= wremain_r - 5'd1;
    end

    assign wremain = wremain_r;
`else
    assign wremain = wtime;
`endif

endmodule

// File: tb/tb_queue_controller.sv
// Scoreboarded bench for queue_controller with a registered ROM model.
module tb_queue_controller;

    localparam int MAXC = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       push_up = 1'b0;
    logic       push_down = 1'b0;
    logic [1:0] Tcount = 2'd0;
    logic [2:0] count;
    logic       full, empty, reject, busy, rom_en, wtime_valid;
    logic [4:0] rom_addr, rom_data, wtime, wremain;

    int n_checks = 0;
    int n_errors = 0;

    queue_controller #(.MAX_COUNT(MAXC)) dut (
        .clk(clk), .reset(reset), .tick(tick), .push_up(push_up), .push_down(push_down),
        .Tcount(Tcount), .count(count), .full(full), .empty(empty), .reject(reject),
        .busy(busy), .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .wtime(wtime), .wtime_valid(wtime_valid), .wremain(wremain)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] rom_fn(input int a);
        return 5'((a * 5 + 12) % 32);
    endfunction

    // Registered ROM: data for the address presented in one cycle appears in the next
    always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0d with nothing expected at %0t", name, act, $time);
    endtask

    // ---------------- reference model ----------------
    int m_count, m_tq, m_phase, m_addr, m_wtime, m_wrem;
    bit m_upp, m_dnp, m_init, m_valid;
    bit pu, pd, pt;
    int ptv;
    int exp_addr[$];
    int exp_wt[$];
    int exp_rej[$];

    // Behavioural model: phase 0 = idle, 1 = ROM read, 2 = capture
    always @(posedge clk) begin
        bit up_e, dn_e, t_e, u, d, tc, any, chg;
        int nt;
        if (reset) begin
            m_count = 0; m_tq = 0; m_phase = 0; m_addr = 0; m_wtime = 0; m_wrem = 0;
            m_upp = 0; m_dnp = 0; m_init = 1; m_valid = 0;
            pu = 0; pd = 0; pt = 0; ptv = 0;
            exp_addr.delete(); exp_wt.delete(); exp_rej.delete();
        end else begin
            up_e = tick && push_up && !m_upp;
            dn_e = tick && push_down && !m_dnp;
            t_e  = tick && (int'(Tcount) != m_tq);
            if (tick) begin m_upp = push_up; m_dnp = push_down; end
            if (m_phase == 0) begin
`ifdef QCTRL_COUNTDOWN_EN
                if (tick && m_wrem > 0) m_wrem--;
`endif
                u = up_e || pu; d = dn_e || pd; tc = t_e || pt;
                any = pu || pd || pt;
                nt = t_e ? int'(Tcount) : ptv;
                pu = 0; pd = 0; pt = 0;
                chg = 0;
                if (u && !d) begin
                    if (m_count == MAXC) exp_rej.push_back(m_count);
                    else begin m_count++; chg = 1; end
                end else if (d && !u) begin
                    if (m_count == 0) exp_rej.push_back(m_count);
                    else begin m_count--; chg = 1; end
                end
                if (tc && nt != m_tq) begin m_tq = nt; chg = 1; end
                if (chg || m_init || any) begin
                    m_phase = 1; m_init = 0; m_valid = 0;
                    m_addr = m_tq * 8 + m_count;
                    exp_addr.push_back(m_addr);
                end
            end else begin
                if (up_e) pu = 1;
                if (dn_e) pd = 1;
                if (t_e) begin pt = 1; ptv = int'(Tcount); end
                if (m_phase == 1) m_phase = 2;
                else begin
                    m_wtime = int'(rom_fn(m_addr));
                    m_valid = 1;
                    m_wrem  = m_wtime;
                    exp_wt.push_back(m_wtime);
                    m_phase = 0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit v_prev = 0;
    always @(negedge clk) begin
        if (rom_en) begin
            if (exp_addr.size() == 0) unexpected("lookup", int'(rom_addr));
            else chk("lookup_addr", int'(rom_addr), exp_addr.pop_front());
        end
        if (wtime_valid && !v_prev) begin
            if (exp_wt.size() == 0) unexpected("capture", int'(wtime));
            else chk("wtime", int'(wtime), exp_wt.pop_front());
        end
        v_prev = wtime_valid;
        if (reject) begin
            if (exp_rej.size() == 0) unexpected("reject", int'(count));
            else chk("reject_count", int'(count), exp_rej.pop_front());
        end
        chk("count", int'(count), m_count);
        chk("full", int'(full), int'(m_count == MAXC));
        chk("empty", int'(empty), int'(m_count == 0));
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("wtime_valid", int'(wtime_valid), int'(m_valid));
`ifdef QCTRL_COUNTDOWN_EN
        chk("wremain", int'(wremain), m_wrem);
`else
        chk("wremain", int'(wremain), m_wtime);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic u, input logic d, input logic [1:0] t, input logic tk);
        @(negedge clk);
        push_up = u; push_down = d; Tcount = t; tick = tk;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic press(input logic u, input logic d, input logic [1:0] t);
        step(u, d, t, 1'b1);
        idle(4);
        step(1'b0, 1'b0, t, 1'b1);
        idle(4);
    endtask

    initial begin
        logic       ru, rd, rtk;
        logic [1:0] rt;
        repeat (3) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_reject", int'(reject), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rom_en", int'(rom_en), 0);
        chk("rst_wtime", int'(wtime), 0);
        chk("rst_wtime_valid", int'(wtime_valid), 0);
        chk("rst_wremain", int'(wremain), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("init_rom_en", int'(rom_en), 1);
        chk("init_rom_addr", int'(rom_addr), 0);
        @(negedge clk);
        chk("init_capture_rom_en", int'(rom_en), 0);
        @(negedge clk);
        chk("init_wtime", int'(wtime), 12);
        chk("init_wtime_valid", int'(wtime_valid), 1);
        idle(3);

        // Two tellers, then fill past the threshold
        step(1'b0, 1'b0, 2'd2, 1'b1);
        idle(4);
        for (int i = 0; i < 8; i++) begin
            press(1'b1, 1'b0, 2'd2);
            if (i == 6) begin
                chk("fill_count", int'(count), 7);
                chk("fill_full", int'(full), 1);
                chk("fill_addr", int'(rom_addr), 5'b10111);
            end
        end
        chk("sat_count", int'(count), 7);

        // Drain, then one departure too many
        for (int i = 0; i < 8; i++) press(1'b0, 1'b1, 2'd2);
        chk("drain_count", int'(count), 0);
        chk("drain_empty", int'(empty), 1);

        // Same-tick arrival and departure at count 3
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 2'd2);
        press(1'b1, 1'b1, 2'd2);
        chk("net_zero_count", int'(count), 3);
        press(1'b1, 1'b1, 2'd3);
        chk("net_zero_tchange_addr", int'(rom_addr), 5'b11011);

        // Back-to-back ticks: second arrival lands during CAPTURE
        step(1'b1, 1'b0, 2'd3, 1'b1);
        step(1'b0, 1'b0, 2'd3, 1'b1);
        step(1'b1, 1'b0, 2'd3, 1'b1);
        step(1'b1, 1'b0, 2'd3, 1'b0);
        idle(8);
        chk("pending_count", int'(count), 5);
        step(1'b0, 1'b0, 2'd3, 1'b1);
        idle(4);

        // Reset during a lookup aborts it
        step(1'b0, 1'b0, 2'd1, 1'b1);
        @(negedge clk);
        tick = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_wtime_valid", int'(wtime_valid), 0);
        chk("abort_count", int'(count), 0);
        reset = 1'b0;
        idle(6);

        // Random traffic against the model
        ru = 1'b0; rd = 1'b0; rt = 2'd1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) ru = ~ru;
            if ($urandom_range(0, 2) == 0) rd = ~rd;
            if ($urandom_range(0, 5) == 0) rt = 2'($urandom_range(0, 3));
            rtk = ($urandom_range(0, 2) == 0);
            step(ru, rd, rt, rtk);
        end
        idle(10);
        chk("leftover_lookups", exp_addr.size(), 0);
        chk("leftover_captures", exp_wt.size(), 0);
        chk("leftover_rejects", exp_rej.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
